fetch: RTL and testbench

- Instruction-fetch stage, directly upstream of the decode stage.
- Each cycle it issues a word address to the 64-bit-wide instruction BRAM, which holds one dual-issue bundle per word and has 1-cycle read latency.
- It presents {pc, inst} to decode, redirects on decode's registered branch_flag/branch_pc, and holds its bundle while decode asserts interlock.
- Bubbles are encoded as a NOP bundle, so decode needs no valid bit.

---
 rtl/core_pkg.sv | 22 ++
 rtl/fetch.sv | 85 ++++++++
 tb/tb_fetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding, opcodes, exec types.
// Imported by fetch and decode.
package core_pkg;

  localparam logic [31:0] NOP_WORD   = {3'b111, 29'b0};
  localparam logic [63:0] NOP_BUNDLE = {NOP_WORD, NOP_WORD};

  localparam logic [5:0] OP_ADD    = 6'b000010;
  localparam logic [5:0] OP_SUB    = 6'b000011;
  localparam logic [5:0] OP_RSHIFT = 6'b000100;
  localparam logic [5:0] OP_LSHIFT = 6'b000101;
  localparam logic [5:0] OP_NOP    = 6'b111000;

  typedef enum logic [2:0] {
    ENop,
    EAdd,
    ESub,
    ERshift,
    ELshift
  } exec_type;

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: issues BRAM reads, presents {pc, inst}
// to decode, holds on interlock and redirects on branch_flag.
module fetch
  import core_pkg::*;
#(
  parameter int          ADDR_W   = 15,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interlock,
  input  logic              branch_flag,
  input  logic [31:0]       branch_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_dout,
  output logic [31:0]       pc,
  output logic [63:0]       inst,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       redirect_cnt
);

  logic [31:0] fpc;
  logic        fl_valid;
  logic [31:0] fl_pc;
  logic        hold_valid;
  logic [63:0] hold_inst;

  // Read request: a redirect issues its target even while stalled
  always_comb begin
    imem_en   = ~rst & (branch_flag | ~interlock);
    imem_addr = branch_flag ? branch_pc[ADDR_W-1:0]
                            : fpc[ADDR_W-1:0];
  end

  // Present NOP when empty, else captured word or live BRAM data
  always_comb begin
    pc   = 32'd0;
    inst = NOP_BUNDLE;
    if (fl_valid) begin
      pc   = fl_pc;
      inst = hold_valid ? hold_inst : imem_dout;
    end
  end

  // Fetch state: redirect beats stall beats sequential advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc        <= RESET_PC;
      fl_valid   <= 1'b0;
      fl_pc      <= 32'd0;
      hold_valid <= 1'b0;
      hold_inst  <= NOP_BUNDLE;
    end else if (branch_flag) begin
      fl_pc      <= branch_pc;
      fl_valid   <= 1'b1;
      fpc        <= branch_pc + 32'd1;
      hold_valid <= 1'b0;
    end else if (interlock) begin
      if (fl_valid && !hold_valid) begin
        hold_inst  <= imem_dout;
        hold_valid <= 1'b1;
      end
    end else begin
      fl_pc      <= fpc;
      fl_valid   <= 1'b1;
      fpc        <= fpc + 32'd1;
      hold_valid <= 1'b0;
    end
  end

  // Perf counters; both wrap silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt    <= 32'd0;
      redirect_cnt <= 32'd0;
    end else begin
      if (branch_flag)
        redirect_cnt <= redirect_cnt + 32'd1;
      else if (interlock)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: vector table plus hand sequences
// for async reset, stall-while-empty and pc wrap.
module tb_fetch;
  import core_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          interlock = 1'b0;
  logic          branch_flag = 1'b0;
  logic [31:0]   branch_pc = 32'd0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [63:0]   imem_dout;
  logic [31:0]   pc;
  logic [63:0]   inst;
  logic [31:0]   stall_cnt;
  logic [31:0]   redirect_cnt;

  logic          garbage = 1'b0;
  logic [63:0]   bram_q = 64'd0;

  int checks = 0;
  int errors = 0;

  fetch #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .interlock(interlock),
    .branch_flag(branch_flag),
    .branch_pc(branch_pc),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_dout(imem_dout),
    .pc(pc),
    .inst(inst),
    .stall_cnt(stall_cnt),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] W(input logic [AW-1:0] a);
    if (a == '0) return 64'h0800_0001_0800_0002;
    return {16'h1000, 1'b0, a, 16'h2000, 1'b0, a};
  endfunction

  // BRAM model, 1-cycle read latency, output held when not enabled
  always @(posedge clk)
    if (imem_en) bram_q <= W(imem_addr);

  assign imem_dout = garbage ? 64'hDEAD_BEEF_BAAD_F00D : bram_q;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic          intl;
    logic          br;
    logic [31:0]   bpc;
    logic          garb;
    logic          en;
    logic [AW-1:0] addr;
    logic [31:0]   epc;
    logic [63:0]   einst;
  } vec_t;

  vec_t v[16];

  function automatic vec_t mk(input logic i, input logic b,
                              input logic [31:0] bp, input logic g,
                              input logic e, input logic [AW-1:0] a,
                              input logic [31:0] p, input logic [63:0] n);
    vec_t r;
    r.intl = i; r.br = b; r.bpc = bp; r.garb = g;
    r.en = e; r.addr = a; r.epc = p; r.einst = n;
    return r;
  endfunction

  task automatic drive(input logic i, input logic b,
                       input logic [31:0] bp, input logic g);
    interlock = i; branch_flag = b; branch_pc = bp; garbage = g;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = mk(0, 0, 0, 0, 1, 15'd0,  32'd0,  NOP_BUNDLE);
    v[1]  = mk(0, 0, 0, 0, 1, 15'd1,  32'd0,  W(15'd0));
    v[2]  = mk(0, 0, 0, 0, 1, 15'd2,  32'd1,  W(15'd1));
    v[3]  = mk(0, 0, 0, 0, 1, 15'd3,  32'd2,  W(15'd2));
    v[4]  = mk(0, 0, 0, 0, 1, 15'd4,  32'd3,  W(15'd3));
    v[5]  = mk(0, 0, 0, 0, 1, 15'd5,  32'd4,  W(15'd4));
    v[6]  = mk(1, 0, 0, 0, 0, 15'd6,  32'd5,  W(15'd5));
    v[7]  = mk(1, 0, 0, 1, 0, 15'd6,  32'd5,  W(15'd5));
    v[8]  = mk(1, 0, 0, 1, 0, 15'd6,  32'd5,  W(15'd5));
    v[9]  = mk(0, 0, 0, 1, 1, 15'd6,  32'd5,  W(15'd5));
    v[10] = mk(0, 0, 0, 0, 1, 15'd7,  32'd6,  W(15'd6));
    v[11] = mk(0, 1, 32'h40, 0, 1, 15'h40, 32'd7, W(15'd7));
    v[12] = mk(0, 0, 0, 0, 1, 15'h41, 32'h40, W(15'h40));
    v[13] = mk(0, 0, 0, 0, 1, 15'h42, 32'h41, W(15'h41));
    v[14] = mk(1, 1, 32'h10, 0, 1, 15'h10, 32'h42, W(15'h42));
    v[15] = mk(0, 0, 0, 0, 1, 15'h11, 32'h10, W(15'h10));

    #1;
    chk("reset_pc", {32'd0, pc}, 64'd0);
    chk("reset_inst", inst, NOP_BUNDLE);
    chk("reset_en", {63'd0, imem_en}, 64'd0);
    next_cycle();
    next_cycle();
    chk("reset_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      drive(v[k].intl, v[k].br, v[k].bpc, v[k].garb);
      @(negedge clk);
      chk($sformatf("v%0d_en", k), {63'd0, imem_en}, {63'd0, v[k].en});
      chk($sformatf("v%0d_addr", k), {49'd0, imem_addr},
          {49'd0, v[k].addr});
      chk($sformatf("v%0d_pc", k), {32'd0, pc}, {32'd0, v[k].epc});
      chk($sformatf("v%0d_inst", k), inst, v[k].einst);
      next_cycle();
    end
    chk("stall_cnt_3", {32'd0, stall_cnt}, 64'd3);
    chk("redirect_cnt_2", {32'd0, redirect_cnt}, 64'd2);

    // enter HELD at pc 0x11, then async reset mid-cycle
    drive(1, 0, 0, 0);
    next_cycle();
    drive(1, 0, 0, 1);
    @(negedge clk);
    chk("held_pc", {32'd0, pc}, 64'h11);
    chk("held_inst", inst, W(15'h11));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", {32'd0, pc}, 64'd0);
    chk("arst_inst", inst, 64'hE000_0000_E000_0000);
    chk("arst_en", {63'd0, imem_en}, 64'd0);
    chk("arst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    chk("arst_redir_cnt", {32'd0, redirect_cnt}, 64'd0);
    next_cycle();

    // release reset while stalled: stays empty, no capture
    drive(1, 0, 0, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("empty_stall_inst0", inst, NOP_BUNDLE);
    chk("empty_stall_en", {63'd0, imem_en}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("empty_stall_inst1", inst, NOP_BUNDLE);
    chk("empty_stall_pc1", {32'd0, pc}, 64'd0);
    next_cycle();
    chk("empty_stall_cnt", {32'd0, stall_cnt}, 64'd2);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("restart_addr", {49'd0, imem_addr}, 64'd0);
    chk("restart_inst0", inst, NOP_BUNDLE);
    next_cycle();
    @(negedge clk);
    chk("restart_pc", {32'd0, pc}, 64'd0);
    chk("restart_inst", inst, W(15'd0));
    next_cycle();

    // wrap: redirect to 0xFFFFFFFF then advance
    drive(0, 1, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    chk("wrap_br_addr", {49'd0, imem_addr}, 64'h7FFF);
    next_cycle();
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_pc", {32'd0, pc}, 64'hFFFF_FFFF);
    chk("wrap_inst", inst, W(15'h7FFF));
    chk("wrap_addr", {49'd0, imem_addr}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("wrap_pc0", {32'd0, pc}, 64'd0);
    chk("wrap_inst0", inst, W(15'd0));
    chk("wrap_redir_cnt", {32'd0, redirect_cnt}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
